// File: rtl/cneg_pkg.sv
// Shared constants for the serial complement/negate unit: mode codes,
// FSM state encoding and default geometry.
package cneg_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cneg_digit.sv
// One digit slice: optional ones-complement of the operand digit plus a
// single-bit carry-in, returning the digit sum and carry-out.
module cneg_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] d,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
    sum  = full[DIGIT-1:0];
    cout = full[DIGIT];
  end

endmodule

// File: rtl/cneg16_serial.sv
// Digit-serial pass / invert / negate / abs unit with a registered carry,
// trading NDIG+2 cycles per operation for a DIGIT-bit adder.
//
// state | meaning
// IDLE  | Ready=1, waiting for Start
// RUN   | one digit per edge, LSB digit first
// DONE  | Done=1 for one cycle, Out/Ovf valid
module cneg16_serial
  import cneg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Mode,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             inv_q;
  logic             carry;
  logic             ovf_pend;

  logic             accept;
  logic             last;
  logic             inv_sel;
  logic             cin_sel;
  logic             ovf_sel;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic [WIDTH-1:0] res_nxt;

  cneg_digit #(.DIGIT(DIGIT)) u_digit (
    .d    (sh[DIGIT-1:0]),
    .inv  (inv_q),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout)
  );

  always_comb begin
    inv_sel = 1'b0;
    cin_sel = 1'b0;
    case (Mode)
      MODE_PASS: begin inv_sel = 1'b0;       cin_sel = 1'b0;       end
      MODE_INV:  begin inv_sel = 1'b1;       cin_sel = 1'b0;       end
      MODE_NEG:  begin inv_sel = 1'b1;       cin_sel = 1'b1;       end
      MODE_ABS:  begin inv_sel = In[WIDTH-1]; cin_sel = In[WIDTH-1]; end
      default:   begin inv_sel = 1'b0;       cin_sel = 1'b0;       end
    endcase
    // only the most-negative value has no representable negation
    ovf_sel = ((Mode == MODE_NEG) || (Mode == MODE_ABS)) &&
              (In == {1'b1, {(WIDTH-1){1'b0}}});
    res_nxt = {dsum, res[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    Done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        Ready  = 1'b1;
        accept = Start;
        if (Start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        last = (cnt == CW'(NDIG - 1));
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        Done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh       <= '0;
      res      <= '0;
      cnt      <= '0;
      inv_q    <= 1'b0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
      Out      <= '0;
      Ovf      <= 1'b0;
    end else if (accept) begin
      sh       <= In;
      inv_q    <= inv_sel;
      carry    <= cin_sel;
      cnt      <= '0;
      ovf_pend <= ovf_sel;
    end else if (state == ST_RUN) begin
      sh    <= sh >> DIGIT;
      res   <= res_nxt;
      carry <= dcout;
      cnt   <= cnt + 1'b1;
      // Out/Ovf only move on the edge entering DONE
      if (last) begin
        Out <= res_nxt;
        Ovf <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_cneg16_serial.sv
// Directed bench for cneg16_serial: hand-computed vectors, cycle-exact
// handshake checks, busy-start rejection and mid-operation reset.
module tb_cneg16_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [15:0] In;
  logic [1:0]  Mode;
  logic        Ready;
  logic        Done;
  logic [15:0] Out;
  logic        Ovf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_out_q = 16'h0000;
  logic        exp_ovf_q = 1'b0;

  cneg16_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .In    (In),
    .Mode  (Mode),
    .Ready (Ready),
    .Done  (Done),
    .Out   (Out),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept edge, three more RUN edges, DONE on the fourth digit edge, IDLE after.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] d,
                        input logic [15:0] eo, input logic ev, input bit busy);
    Start = 1'b1;
    In    = d;
    Mode  = m;
    step();
    Start = 1'b0;
    In    = 16'($urandom);
    Mode  = 2'($urandom);
    if (busy) begin
      Start = 1'b1;
      Mode  = 2'b00;
      In    = 16'h5555;
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      chk({tag, " ready_run"}, 32'(Ready), 32'(1'b0));
      chk({tag, " done_run"},  32'(Done),  32'(1'b0));
      chk({tag, " out_hold"},  32'(Out),   32'(exp_out_q));
      chk({tag, " ovf_hold"},  32'(Ovf),   32'(exp_ovf_q));
    end
    Start = 1'b0;
    step();
    chk({tag, " done"},       32'(Done),  32'(1'b1));
    chk({tag, " ready_done"}, 32'(Ready), 32'(1'b0));
    chk({tag, " out"},        32'(Out),   32'(eo));
    chk({tag, " ovf"},        32'(Ovf),   32'(ev));
    exp_out_q = eo;
    exp_ovf_q = ev;
    step();
    chk({tag, " done_clr"},  32'(Done),  32'(1'b0));
    chk({tag, " ready_idle"}, 32'(Ready), 32'(1'b1));
    chk({tag, " out_idle"},  32'(Out),   32'(eo));
  endtask

  initial begin
    rst_n = 1'b0;
    Start = 1'b0;
    In    = 16'h0000;
    Mode  = 2'b00;
    #23;
    chk("rst ready", 32'(Ready), 32'(1'b1));
    chk("rst done",  32'(Done),  32'(1'b0));
    chk("rst out",   32'(Out),   32'(16'h0000));
    chk("rst ovf",   32'(Ovf),   32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst ready", 32'(Ready), 32'(1'b1));

    run_op("neg1",    2'b10, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op("inv00ff", 2'b01, 16'h00FF, 16'hFF00, 1'b0, 1'b0);
    run_op("pass",    2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0);
    run_op("abs_neg", 2'b11, 16'hFFF6, 16'h000A, 1'b0, 1'b0);
    run_op("abs_pos", 2'b11, 16'h0007, 16'h0007, 1'b0, 1'b0);
    run_op("neg8000", 2'b10, 16'h8000, 16'h8000, 1'b1, 1'b0);
    run_op("neg0",    2'b10, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("abs8000", 2'b11, 16'h8000, 16'h8000, 1'b1, 1'b0);
    run_op("inv_a5",  2'b01, 16'hA5C3, 16'h5A3C, 1'b0, 1'b0);
    run_op("busy",    2'b10, 16'h0100, 16'hFF00, 1'b0, 1'b1);

    // reset abandons an in-flight operation
    Start = 1'b1;
    In    = 16'h0005;
    Mode  = 2'b10;
    step();
    Start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst out",   32'(Out),   32'(16'h0000));
    chk("midrst ovf",   32'(Ovf),   32'(1'b0));
    chk("midrst ready", 32'(Ready), 32'(1'b1));
    chk("midrst done",  32'(Done),  32'(1'b0));
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    exp_out_q = 16'h0000;
    exp_ovf_q = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("postrst done",  32'(Done),  32'(1'b0));
      chk("postrst ready", 32'(Ready), 32'(1'b1));
      chk("postrst out",   32'(Out),   32'(16'h0000));
    end

    // Start held high: accept every 6 edges, Done after edge 4 of each
    Start = 1'b1;
    In    = 16'h0002;
    Mode  = 2'b10;
    for (int i = 0; i < 18; i++) begin
      step();
      chk("stream done",  32'(Done),  32'((i % 6) == 4));
      chk("stream ready", 32'(Ready), 32'((i % 6) == 5));
      if ((i % 6) == 4) begin
        chk("stream out", 32'(Out), 32'(16'hFFFE));
        chk("stream ovf", 32'(Ovf), 32'(1'b0));
      end
    end
    Start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
